// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch stage and the control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [ILEN-1:0] INSTR_NOP    = 32'h0000_0013;   // addi x0, x0, 0

    // Major opcodes, shared with the control unit decoder.
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    // Width of the count of killed responses still owed by memory. Every
    // redirect can add at most DEPTH, so this only overflows if memory
    // withholds responses across a long burst of redirects.
    localparam int DROP_W = 8;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FLUSH = 1'b1
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch_entry_t with a single-cycle flush.
// Latency: push visible at head_dat_o the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
//
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/push_dat_i
// write; pop_i removes the head; flush_i empties the FIFO and wins over
// push/pop; head_dat_o is the oldest entry (undefined when empty_o);
// full_o/empty_o/count_o report occupancy.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  fetch_entry_t     push_dat_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop, mem_we;

    assign do_pop  = pop_i && (count_q != '0);
    // A pop frees the slot, so push-while-full is fine when paired with a pop.
    assign do_push = push_i && ((count_q != DEPTH_C) || do_pop);
    assign mem_we  = do_push && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; consumers qualify it with empty_o.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == DEPTH_C);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads, queues {instr, pc} for decode.
// Latency: gnt in cycle N, rvalid N+1, instr_valid_o N+2; 1 instr/cycle sustained.
// Backpressure: stops requesting once queued + outstanding fetches reach DEPTH.
//
// Ports: clk_i/rst_ni clock and async active-low reset; imem_* is the
// req/gnt/rvalid instruction memory port (responses in request order);
// instr_valid_o/instr_ready_i hand instr_o, pc_o and pc_plus4_o to decode;
// PCSrc_i/pc_target_i redirect fetch and kill everything younger.
// ADDR_WIDTH/INSTR_WIDTH must match XLEN/ILEN of riscv_pkg, which size the
// queue entries.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = XLEN,
    parameter int                    INSTR_WIDTH = ILEN,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'hBFC0_0000,
    parameter int                    DEPTH       = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  pc_o,
    output logic [ADDR_WIDTH-1:0]  pc_plus4_o,
    input  logic                   PCSrc_i,
    input  logic [ADDR_WIDTH-1:0]  pc_target_i
);

    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [DROP_W-1:0]     drop_q, drop_d;
    logic                  issue_en_q, issue_en_d;
    logic                  req_seen_q, req_seen_d;
    fetch_state_e          state_q;

    fetch_entry_t          q_push_dat, q_head;
    logic                  q_push, q_full, q_empty;
    logic [CNT_W-1:0]      q_count;
    fetch_entry_t          pend_push_dat, pend_head;
    logic                  pend_full, pend_empty;
    logic [CNT_W-1:0]      pend_count;

    logic                  pop, hs, rsp_drop, rsp_take;
    logic [CNT_W:0]        in_use;
    logic [CNT_W-1:0]      out_after;
    logic [DROP_W-1:0]     drop_after;

    // ---------------------------------------------------------------
    // Issue: capacity counts words already queued plus words still in
    // flight, so every granted fetch is guaranteed a queue slot. The head
    // being popped this cycle frees its slot immediately, which is what
    // sustains one instruction per cycle with DEPTH=2.
    // ---------------------------------------------------------------
    assign pop    = instr_valid_o && instr_ready_i;
    assign in_use = (CNT_W + 1)'(q_count) + (CNT_W + 1)'(outstanding_q)
                  - (CNT_W + 1)'(pop);

    // issue_en_q holds off requests for the reset cycle itself, so the
    // request output is low while reset is asserted.
    assign imem_req_o  = issue_en_q && !PCSrc_i && (in_use < DEPTH_C);
    assign imem_addr_o = fetch_pc_q;
    assign hs          = imem_req_o && imem_gnt_i;

    // ---------------------------------------------------------------
    // Responses: while killed fetches are still owed (FLUSH) the next
    // rvalid belongs to one of them. An rvalid with nothing owed at all is
    // a leftover from before reset and is ignored.
    // ---------------------------------------------------------------
    assign rsp_drop = imem_rvalid_i && (state_q == FETCH_FLUSH);
    assign rsp_take = imem_rvalid_i && (state_q == FETCH_RUN) && (outstanding_q != '0);

    assign out_after  = outstanding_q - CNT_W'(rsp_take);
    assign drop_after = drop_q - DROP_W'(rsp_drop);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = out_after + CNT_W'(hs);
        drop_d        = drop_after;
        issue_en_d    = 1'b1;
        req_seen_d    = req_seen_q | hs;
        if (hs) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
        if (PCSrc_i) begin
            // Everything still in flight is now owed as a discard; a word
            // arriving this very cycle has already been subtracted.
            fetch_pc_d    = word_align(pc_target_i);
            outstanding_d = '0;
            drop_d        = drop_after + DROP_W'(out_after);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            issue_en_q    <= 1'b0;
            req_seen_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            issue_en_q    <= issue_en_d;
            req_seen_q    <= req_seen_d;
        end
    end

    // RUN/FLUSH tracks whether killed responses are still owed; it is in
    // FLUSH exactly when drop_q is nonzero. New fetches may issue in FLUSH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FETCH_RUN;
        end else begin
            case (state_q)
                FETCH_RUN:   if (PCSrc_i && (drop_d != '0)) state_q <= FETCH_FLUSH;
                FETCH_FLUSH: if (drop_d == '0)              state_q <= FETCH_RUN;
                default:                                    state_q <= FETCH_RUN;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Pending-PC FIFO: the address of each granted fetch, matched to its
    // response by order. Only the pc field is meaningful.
    // ---------------------------------------------------------------
    assign pend_push_dat = '{instr: '0, pc: fetch_pc_q};

    fetch_fifo #(.DEPTH(DEPTH)) u_pend_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (hs),
        .push_dat_i (pend_push_dat),
        .pop_i      (rsp_take),
        .flush_i    (PCSrc_i),
        .head_dat_o (pend_head),
        .full_o     (pend_full),
        .empty_o    (pend_empty),
        .count_o    (pend_count)
    );

    // Instruction queue. A word returning in a redirect cycle is dropped.
    assign q_push     = rsp_take && !PCSrc_i;
    assign q_push_dat = '{instr: imem_rdata_i, pc: pend_head.pc};

    fetch_fifo #(.DEPTH(DEPTH)) u_instr_q (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (q_push),
        .push_dat_i (q_push_dat),
        .pop_i      (pop),
        .flush_i    (PCSrc_i),
        .head_dat_o (q_head),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .count_o    (q_count)
    );

    // Outputs come straight from queue storage; rdata never reaches instr_o
    // in the same cycle.
    assign instr_valid_o = !q_empty;
    assign instr_o       = q_empty ? INSTR_NOP : q_head.instr;
    assign pc_o          = q_empty ? RESET_PC  : q_head.pc;
    assign pc_plus4_o    = pc_o + ADDR_WIDTH'(4);

    // ---------------------------------------------------------------
    // Invariants
    // ---------------------------------------------------------------
    a_capacity: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((CNT_W + 1)'(q_count) + (CNT_W + 1)'(outstanding_q)) <= DEPTH_C);

    a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(imem_rvalid_i && req_seen_q && (outstanding_q == '0) && (drop_q == '0)));

    a_pend_tracks_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pend_count == outstanding_q);

    a_pend_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(hs && pend_full));

    a_pend_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rsp_take && pend_empty));

    a_pend_pc_only: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pend_empty || (pend_head.instr == '0));

    a_queue_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(q_push && q_full && !pop));

    a_flush_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == FETCH_FLUSH) == (drop_q != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a PC-sequence reference model.
// Latency: n/a (bench).
// Backpressure: randomized gnt/rvalid/ready from a bench-side memory model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        PCSrc_i = 1'b0;
    logic [31:0] pc_target_i = '0;

    instr_fetch_unit dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .PCSrc_i       (PCSrc_i),
        .pc_target_i   (pc_target_i)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Memory model: addresses granted but not yet answered, oldest first.
    logic [31:0] resp_q[$];
    // Reference model: next PC decode must see, next address fetch must issue.
    logic [31:0] exp_pc, exp_fetch;

    int p_gnt, p_rv, p_rdy, p_redir;   // percent, percent, percent, per-mille
    bit stale_rv = 1'b0;
    int cycle = 0, hs_cnt = 0, pop_cnt = 0;

    bit          obs_req, obs_hs, obs_valid, obs_pop, from_q;
    logic [31:0] obs_addr, obs_pc;
    int          obs_cyc;

    // Instruction memory contents: a bijection of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1ns later, update models at posedge.
    task automatic step(input bit force_redir = 1'b0, input logic [31:0] tgt = 32'h0);
        logic [31:0] r, e4;
        @(negedge clk_i);
        imem_gnt_i    = ($urandom_range(99) < p_gnt);
        instr_ready_i = ($urandom_range(99) < p_rdy);
        from_q        = (resp_q.size() > 0) && ($urandom_range(99) < p_rv);
        imem_rvalid_i = from_q || stale_rv;
        if (from_q)        imem_rdata_i = mem_word(resp_q[0]);
        else if (stale_rv) imem_rdata_i = ~mem_word(RST_PC);
        else               imem_rdata_i = $urandom;
        stale_rv = 1'b0;
        r = $urandom;
        if (force_redir)          pc_target_i = tgt;
        else if (r[3:0] == 4'h0)  pc_target_i = 32'hFFFF_FFF0 | {28'h0, r[7:4]};
        else                      pc_target_i = {20'hBFC00, r[15:4]};
        PCSrc_i = force_redir || ($urandom_range(999) < p_redir);
        #1;
        obs_req   = imem_req_o;
        obs_addr  = imem_addr_o;
        obs_valid = instr_valid_o;
        obs_pc    = pc_o;
        obs_hs    = obs_req && imem_gnt_i;
        obs_pop   = obs_valid && instr_ready_i;
        obs_cyc   = cycle;
        if (PCSrc_i) check_eq("req_in_redirect", obs_req, 0);
        if (obs_hs)  check_eq("fetch_addr", obs_addr, exp_fetch);
        if (obs_pop) begin
            e4 = exp_pc + 32'd4;
            check_eq("pc_o", pc_o, exp_pc);
            check_eq("instr_o", instr_o, mem_word(exp_pc));
            check_eq("pc_plus4_o", pc_plus4_o, e4);
        end else if (!obs_valid) begin
            check_eq("nop_when_empty", instr_o, NOP);
        end
        @(posedge clk_i);
        cycle++;
        if (obs_hs) begin
            resp_q.push_back(obs_addr);
            exp_fetch = exp_fetch + 32'd4;
            hs_cnt++;
        end
        if (from_q) void'(resp_q.pop_front());
        if (obs_pop) begin
            exp_pc = exp_pc + 32'd4;
            pop_cnt++;
        end
        if (PCSrc_i) begin
            exp_pc    = {pc_target_i[31:2], 2'b00};
            exp_fetch = {pc_target_i[31:2], 2'b00};
        end
    endtask

    task automatic do_reset(input bit stale);
        logic [31:0] rp4;
        rp4 = RST_PC + 32'd4;
        @(negedge clk_i);
        rst_ni        = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        instr_ready_i = 1'b0;
        PCSrc_i       = 1'b0;
        #1;
        check_eq("rst_req", imem_req_o, 0);
        check_eq("rst_valid", instr_valid_o, 0);
        check_eq("rst_instr", instr_o, NOP);
        check_eq("rst_pc", pc_o, RST_PC);
        check_eq("rst_pc_plus4", pc_plus4_o, rp4);
        @(negedge clk_i);
        rst_ni = 1'b1;
        resp_q.delete();
        exp_pc    = RST_PC;
        exp_fetch = RST_PC;
        stale_rv  = stale;
    endtask

    // Step until decode sees a valid head (bounded); returns its PC.
    task automatic wait_valid(input string tag, output logic [31:0] pc);
        bit got = 1'b0;
        pc = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (obs_valid) begin
                got = 1'b1;
                pc  = obs_pc;
            end
        end
        check_eq(tag, got, 1);
    endtask

    initial begin
        int first_gnt, first_vld, gaps, hs0;
        logic [31:0] a0, vpc;

        // 1. Streaming from reset with an ideal memory.
        p_gnt = 100; p_rv = 100; p_rdy = 100; p_redir = 0;
        do_reset(1'b0);
        first_gnt = -1; first_vld = -1; gaps = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (obs_hs && first_gnt < 0)    first_gnt = obs_cyc;
            if (obs_valid && first_vld < 0) first_vld = obs_cyc;
            if (first_gnt >= 0 && !obs_hs)    gaps++;
            if (first_vld >= 0 && !obs_valid) gaps++;
        end
        check_eq("t1_first_valid_latency", first_vld - first_gnt, 2);
        check_eq("t1_gaps", gaps, 0);

        // 2. Decode stalls for 5 cycles.
        p_rdy = 0;
        hs0 = hs_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t2_valid_held", obs_valid, 1);
        end
        check_eq("t2_req_dropped", obs_req, 0);
        check_eq("t2_extra_reqs_le2", (hs_cnt - hs0) <= 2, 1);
        p_rdy = 100;
        for (int i = 0; i < 6; i++) step();

        // 3. Redirect with two fetches in flight.
        p_rv = 0;
        for (int i = 0; i < 4; i++) step();
        check_eq("t3_two_outstanding", resp_q.size(), 2);
        step(1'b1, 32'hBFC0_0040);
        p_rv = 100;
        wait_valid("t3_valid_after_redirect", vpc);
        check_eq("t3_first_pc", vpc, 32'hBFC0_0040);
        for (int i = 0; i < 4; i++) step();

        // 4. Back-to-back redirects, last one misaligned.
        step(1'b1, 32'hBFC0_0100);
        step(1'b1, 32'hBFC0_0046);
        step();
        check_eq("t4_req_resumes", obs_req, 1);
        check_eq("t4_aligned_addr", obs_addr, 32'hBFC0_0044);
        for (int i = 0; i < 5; i++) step();

        // 5. Grant withheld for 3 cycles.
        p_gnt = 0;
        step(1'b1, 32'hBFC0_0200);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t5_req_held", obs_req, 1);
            check_eq("t5_addr_stable", obs_addr, 32'hBFC0_0200);
        end
        p_gnt = 100;
        step();
        check_eq("t5_granted_addr", obs_hs ? obs_addr : 32'h0, 32'hBFC0_0200);
        for (int i = 0; i < 4; i++) step();

        // PC wrap at the top of the address space.
        step(1'b1, 32'hFFFF_FFF8);
        wait_valid("wrap_valid", vpc);
        check_eq("wrap_first_pc", vpc, 32'hFFFF_FFF8);
        for (int i = 0; i < 6; i++) step();

        // 6. Reset mid-stream with a response still owed.
        p_rv = 0;
        for (int i = 0; i < 3; i++) step();
        check_eq("t6_inflight_before_reset", resp_q.size() > 0, 1);
        do_reset(1'b1);
        p_rv = 100;
        wait_valid("t6_valid_after_reset", vpc);
        check_eq("t6_restart_pc", vpc, RST_PC);
        for (int i = 0; i < 6; i++) step();

        // 7. Random traffic.
        p_gnt = 60; p_rv = 60; p_rdy = 70; p_redir = 30;
        pop_cnt = 0;
        for (int i = 0; i < 10000; i++) step();
        check_eq("t7_progress", pop_cnt > 1000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
